hbmc_wdata_sequencer: RTL

Memory-clock write-data sequencer that drains the downstream data FIFO during a HyperBus write burst. It pops 16-bit words and byte strobes from the FIFO's first-word-fall-through read port. It presents them to the DDR output stage as one registered word per clock, with a RWDS byte mask. If the FIFO runs dry mid-burst, it keeps the burst cadence by emitting fully masked words and raises a sticky underrun flag.

---
 rtl/hbmc_wdata_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/hbmc_wdata_sequencer.sv
// HyperBus write-data sequencer: drains the FWFT data FIFO into the DDR output stage
// one registered word per clock, padding with fully masked words if the FIFO runs dry.
module hbmc_wdata_sequencer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] cmd_word_count,

    input  logic [15:0]          fifo_rd_dout,
    input  logic [1:0]           fifo_rd_strb,
    input  logic                 fifo_rd_empty,
    output logic                 fifo_rd_ena,

    output logic [15:0]          dq_data,
    output logic [1:0]           rwds_mask,
    output logic                 dq_valid,
    output logic                 dq_last,
    output logic                 done,

    output logic                 underrun,
    input  logic                 underrun_clr
);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RemOne = CNT_WIDTH'(1);

    state_e               state;
    logic [CNT_WIDTH-1:0] rem;
    logic                 rem_is_one;
    logic                 draining;

    assign rem_is_one = (rem == RemOne);
    assign draining   = (state == StPrime) || (state == StStream);

    // Reset gates the handshakes combinationally so nothing is popped or accepted during rst.
    assign cmd_ready   = ~rst & (state == StIdle);
    assign fifo_rd_ena = ~rst & draining & ~fifo_rd_empty;
    assign done        = (state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rem       <= '0;
            dq_data   <= 16'h0000;
            rwds_mask <= 2'b11;
            dq_valid  <= 1'b0;
            dq_last   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            dq_valid  <= 1'b0;
            dq_last   <= 1'b0;
            rwds_mask <= 2'b11;
            // Clear first so a same-cycle underrun event below takes priority.
            if (underrun_clr) begin
                underrun <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        rem   <= cmd_word_count;
                        state <= (cmd_word_count == '0) ? StDone : StPrime;
                    end
                end
                StPrime: begin
                    if (!fifo_rd_empty) begin
                        dq_data   <= fifo_rd_dout;
                        rwds_mask <= ~fifo_rd_strb;
                        dq_valid  <= 1'b1;
                        dq_last   <= rem_is_one;
                        rem       <= rem - RemOne;
                        state     <= rem_is_one ? StDone : StStream;
                    end
                end
                StStream: begin
                    // Burst cadence is fixed: a beat goes out every cycle, real or padded.
                    dq_valid <= 1'b1;
                    dq_last  <= rem_is_one;
                    rem      <= rem - RemOne;
                    if (!fifo_rd_empty) begin
                        dq_data   <= fifo_rd_dout;
                        rwds_mask <= ~fifo_rd_strb;
                    end else begin
                        underrun <= 1'b1;
                    end
                    if (rem_is_one) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
